// File: rtl/fxp_divider.sv
// Sequential fixed-point divider: (dividend * 2^FRAC) / divisor, restoring,
// one quotient bit per cycle, unsigned or two's complement per transaction.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready are
// both high. in_ready is high only in IDLE; out_valid is high only in DONE, and
// the results stay stable until the cycle where out_ready accepts them.
module fxp_divider #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);
  localparam int N  = WIDTH + FRAC;
  localparam int CW = $clog2(N + 1);

  localparam logic [WIDTH-1:0] S_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] S_MIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [N:0]       ONE_X = 1;
  localparam logic [N:0]       U_LIM = (ONE_X << WIDTH) - ONE_X;
  localparam logic [N:0]       P_LIM = (ONE_X << (WIDTH - 1)) - ONE_X;
  localparam logic [N:0]       M_LIM = ONE_X << (WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_next;

  logic [CW-1:0]    count;
  logic [N-1:0]     acc;      // shifted dividend magnitude in, quotient bits out
  logic [N-1:0]     prem;     // partial remainder
  logic [WIDTH-1:0] dvs_mag;
  logic             sign_r, res_neg, dvd_neg;

  logic             dvd_neg_in, dvs_neg_in;
  logic [WIDTH-1:0] dvd_mag_in, dvs_mag_in, dz_quot;
  logic [N:0]       shifted;
  logic [N-1:0]     dvs_ext, prem_next, q_full;
  logic             ge;
  logic [N:0]       lim;
  logic             ovf;
  logic [WIDTH-1:0] sat, q_low, q_val, r_low, r_val;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  assign dvd_neg_in = in_sign & dividend[WIDTH-1];
  assign dvs_neg_in = in_sign & divisor[WIDTH-1];
  assign dvd_mag_in = dvd_neg_in ? (~dividend + 1'b1) : dividend;
  assign dvs_mag_in = dvs_neg_in ? (~divisor + 1'b1) : divisor;
  assign dz_quot    = !in_sign ? {WIDTH{1'b1}} : (dividend[WIDTH-1] ? S_MIN : S_MAX);

  // One restoring step; the remainder always stays below the divisor magnitude.
  assign dvs_ext   = N'(dvs_mag);
  assign shifted   = {prem, acc[N-1]};
  assign ge        = shifted >= {1'b0, dvs_ext};
  assign prem_next = ge ? (shifted[N-1:0] - dvs_ext) : shifted[N-1:0];
  assign q_full    = {acc[N-2:0], ge};

  assign lim   = !sign_r ? U_LIM : (res_neg ? M_LIM : P_LIM);
  assign ovf   = {1'b0, q_full} > lim;
  assign sat   = !sign_r ? {WIDTH{1'b1}} : (res_neg ? S_MIN : S_MAX);
  assign q_low = q_full[WIDTH-1:0];
  assign q_val = res_neg ? (~q_low + 1'b1) : q_low;
  assign r_low = prem_next[WIDTH-1:0];
  assign r_val = dvd_neg ? (~r_low + 1'b1) : r_low;

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (in_valid) state_next = (divisor == '0) ? DONE : CALC;
      CALC: if (count == CW'(1)) state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      count       <= '0;
      acc         <= '0;
      prem        <= '0;
      dvs_mag     <= '0;
      sign_r      <= 1'b0;
      res_neg     <= 1'b0;
      dvd_neg     <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sign_r  <= in_sign;
            res_neg <= in_sign & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            dvd_neg <= dvd_neg_in;
            dvs_mag <= dvs_mag_in;
            acc     <= N'(dvd_mag_in) << FRAC;
            prem    <= '0;
            count   <= CW'(N);
            if (divisor == '0) begin
              quotient    <= dz_quot;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              overflow    <= 1'b0;
            end
          end
        end
        CALC: begin
          acc   <= q_full;
          prem  <= prem_next;
          count <= count - CW'(1);
          if (count == CW'(1)) begin
            quotient    <= ovf ? sat : q_val;
            remainder   <= r_val;
            div_by_zero <= 1'b0;
            overflow    <= ovf;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fxp_divider.sv
// Self-checking bench for fxp_divider (WIDTH=16, FRAC=8): directed vectors,
// arithmetic reference model, per-cycle output scoreboard.
module tb_fxp_divider;
  localparam int WIDTH = 16;
  localparam int FRAC  = 8;
  localparam int N     = WIDTH + FRAC;
  localparam int W     = 2 * WIDTH + 2;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             in_sign = 1'b0;
  logic [WIDTH-1:0] dividend = '0;
  logic [WIDTH-1:0] divisor = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;
  logic             overflow;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;

  fxp_divider #(.WIDTH(WIDTH), .FRAC(FRAC)) dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready), .in_sign(in_sign),
    .dividend(dividend), .divisor(divisor),
    .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero), .overflow(overflow)
  );

  // Reference: {quotient, remainder, div_by_zero, overflow} from plain integer maths.
  function automatic logic [W-1:0] model(input logic s, input logic [15:0] a, input logic [15:0] b);
    longint am, bm, qm, rm;
    logic an, bn, neg, ov;
    logic [63:0] tv;
    logic [15:0] q, r;
    an = s & a[15];
    bn = s & b[15];
    am = an ? 65536 - longint'(a) : longint'(a);
    bm = bn ? 65536 - longint'(b) : longint'(b);
    if (b == 16'h0) begin
      q = !s ? 16'hFFFF : (a[15] ? 16'h8000 : 16'h7FFF);
      return {q, a, 1'b1, 1'b0};
    end
    qm  = (am * 256) / bm;
    rm  = (am * 256) % bm;
    neg = an ^ bn;
    if (!s) begin
      ov = qm > 65535; tv = qm;
    end else if (neg) begin
      ov = qm > 32768; tv = -qm;
    end else begin
      ov = qm > 32767; tv = qm;
    end
    q  = ov ? (!s ? 16'hFFFF : (neg ? 16'h8000 : 16'h7FFF)) : tv[15:0];
    tv = an ? -rm : rm;
    r  = tv[15:0];
    return {q, r, 1'b0, ov};
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every cycle out_valid is high the outputs must match the head entry.
  always @(negedge clk) begin
    if (resetn && out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: out_valid=1 with no expected result");
      end else begin
        check("result", {quotient, remainder, div_by_zero, overflow}, exp_q[0]);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic send(input logic s, input logic [15:0] a, input logic [15:0] b);
    int guard;
    guard = 0;
    in_sign = s; dividend = a; divisor = b; in_valid = 1'b1;
    while (!in_ready && guard < 100) begin
      @(posedge clk); #1; guard++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: in_ready=0 expected 1");
    end
    exp_q.push_back(model(s, a, b));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string name, input int exp_edges);
    int cnt;
    cnt = 0;
    while (!out_valid && cnt < 60) begin
      @(posedge clk); #1; cnt++;
    end
    check(name, W'(cnt), W'(exp_edges));
  endtask

  task automatic run(input string name, input logic s, input logic [15:0] a, input logic [15:0] b);
    send(s, a, b);
    wait_out(name, (b == 16'h0) ? 0 : N);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs", W'({out_valid, quotient, remainder, div_by_zero, overflow}), '0);
    check("rst_in_ready", W'(in_ready), W'(1));
    resetn = 1'b1;
    @(posedge clk); #1;
    check("idle_in_ready", W'(in_ready), W'(1));

    // Hand-computed values pin the reference model.
    check("pin_3_over_2",   model(0, 16'h0300, 16'h0200), {16'h0180, 16'h0000, 2'b00});
    check("pin_neg7p5",     model(1, 16'hF880, 16'h0200), {16'hFC40, 16'h0000, 2'b00});
    check("pin_1_over_3",   model(0, 16'h0001, 16'h0003), {16'h0055, 16'h0001, 2'b00});
    check("pin_m1_over_3",  model(1, 16'hFFFF, 16'h0003), {16'hFFAB, 16'hFFFF, 2'b00});
    check("pin_dz_sneg",    model(1, 16'h8000, 16'h0000), {16'h8000, 16'h8000, 2'b10});
    check("pin_dz_spos",    model(1, 16'h0100, 16'h0000), {16'h7FFF, 16'h0100, 2'b10});
    check("pin_dz_uns",     model(0, 16'h1234, 16'h0000), {16'hFFFF, 16'h1234, 2'b10});
    check("pin_ovf_uns",    model(0, 16'h1000, 16'h0001), {16'hFFFF, 16'h0000, 2'b01});
    check("pin_ovf_sgn",    model(1, 16'h8000, 16'hFF00), {16'h7FFF, 16'h0000, 2'b01});
    check("pin_min_bound",  model(1, 16'h8000, 16'h0100), {16'h8000, 16'h0000, 2'b00});
    check("pin_5_over_m3",  model(1, 16'h0500, 16'hFD00), {16'hFE56, 16'h0200, 2'b00});

    run("lat_3_over_2",  0, 16'h0300, 16'h0200);
    run("lat_neg7p5",    1, 16'hF880, 16'h0200);
    run("lat_1_over_3",  0, 16'h0001, 16'h0003);
    run("lat_m1_over_3", 1, 16'hFFFF, 16'h0003);
    run("lat_dz_sneg",   1, 16'h8000, 16'h0000);
    run("lat_dz_spos",   1, 16'h0100, 16'h0000);
    run("lat_dz_uns",    0, 16'h1234, 16'h0000);
    run("lat_ovf_uns",   0, 16'h1000, 16'h0001);
    run("lat_ovf_sgn",   1, 16'h8000, 16'hFF00);
    run("lat_min_bound", 1, 16'h8000, 16'h0100);
    run("lat_5_over_m3", 1, 16'h0500, 16'hFD00);
    run("lat_back2back", 0, 16'h7FFF, 16'h0001);

    // Backpressure with new operands waiting.
    out_ready = 1'b0;
    send(0, 16'h0300, 16'h0200);
    wait_out("bp_latency", N);
    in_sign = 1'b0; dividend = 16'h0200; divisor = 16'h0400; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_in_ready_low", W'(in_ready), '0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_idle_after_drain", W'({in_ready, out_valid}), W'(2'b10));
    exp_q.push_back(model(0, 16'h0200, 16'h0400));
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_pending_accepted", W'(in_ready), '0);
    wait_out("bp_pending_latency", N);
    @(posedge clk); #1;

    // Reset in the middle of a calculation.
    send(0, 16'h0300, 16'h0200);
    repeat (9) begin
      @(posedge clk); #1;
    end
    resetn = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    check("midrst_outputs", W'({out_valid, quotient, remainder, div_by_zero, overflow}), '0);
    resetn = 1'b1;
    @(posedge clk); #1;
    check("midrst_in_ready", W'(in_ready), W'(1));
    run("midrst_rerun_latency", 0, 16'h0300, 16'h0200);

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", W'(exp_q.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
